// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: one register stage per shift-amount bit, valid/ready on both sides.
// Rotate-left (mode 11) is only built when BSH_ROTATE_EN is defined; otherwise mode 11 shifts left.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_mode
);
    localparam int SHW = $clog2(WIDTH);

    logic             stage_valid [SHW];
    logic [WIDTH-1:0] stage_data  [SHW];
    logic [1:0]       stage_mode  [SHW];
    logic             adv;

    // A single enable moves or freezes the whole pipe, so bubbles keep their slots.
    assign adv      = ~stage_valid[SHW-1] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int STEP = 1 << k;

        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic [1:0]       prev_mode;
        logic             shift_en;
        logic [WIDTH-1:0] shifted;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic [1:0]       mode_q;

        if (k == 0) begin : g_src
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
            assign prev_mode  = in_mode;
            assign shift_en   = in_shamt[0];
        end else begin : g_src
            assign prev_valid = stage_valid[k-1];
            assign prev_data  = stage_data[k-1];
            assign prev_mode  = stage_mode[k-1];
            assign shift_en   = g_stage[k-1].g_rem.rem_q[0];
        end

        // Shift-amount bits not yet consumed travel alongside the data; the last stage needs none.
        if (k < SHW - 1) begin : g_rem
            logic [SHW-2-k:0] rem_q;
            logic [SHW-2-k:0] rem_next;

            if (k == 0) begin : g_from_in
                assign rem_next = in_shamt[SHW-1:1];
            end else begin : g_from_prev
                assign rem_next = g_stage[k-1].g_rem.rem_q[SHW-1-k:1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_q <= '0;
                end else if (adv) begin
                    rem_q <= rem_next;
                end
            end
        end

        always_comb begin
            shifted = prev_data << STEP;
            case (prev_mode)
                2'b01:   shifted = prev_data >> STEP;
                2'b10:   shifted = $signed(prev_data) >>> STEP;
`ifdef BSH_ROTATE_EN
                2'b11:   shifted = (prev_data << STEP) | (prev_data >> (WIDTH - STEP));
`endif
                default: shifted = prev_data << STEP;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                mode_q  <= 2'b00;
            end else if (adv) begin
                valid_q <= prev_valid;
                data_q  <= shift_en ? shifted : prev_data;
                mode_q  <= prev_mode;
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_data[k]  = data_q;
        assign stage_mode[k]  = mode_q;
    end

    assign out_valid = stage_valid[SHW-1];
    assign out_data  = stage_data[SHW-1];
    assign out_mode  = stage_mode[SHW-1];

endmodule
